// File: rtl/arith_pkg.sv
// Shared definitions for the integer arithmetic datapath.
//   WIDTH_DEFAULT / GROUP_DEFAULT : default operand width and lookahead group size
//   GROUP_MAX                     : widest lookahead group cla_carries supports
//   cla_carries(p, g, ci)         : flat lookahead carries c[0..GROUP_MAX] of one group,
//                                   c[0] = ci, c[i] = carry into bit i (c[n] = group carry out)
package arith_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned GROUP_DEFAULT = 4;
  localparam int unsigned GROUP_MAX     = 8;

  // Each carry is an independent sum of products:
  //   c[i] = OR over j<=i of ( src[j] & p[j] & ... & p[i-1] ), src = {g, ci}
  // so no carry depends on another carry. Callers zero-extend narrower groups
  // and read only the low GROUP+1 bits.
  function automatic logic [GROUP_MAX:0] cla_carries(
    input logic [GROUP_MAX-1:0] p,
    input logic [GROUP_MAX-1:0] g,
    input logic                 ci
  );
    logic [GROUP_MAX:0] src;
    logic [GROUP_MAX:0] c;
    logic               term;
    src = {g, ci};
    c   = '0;
    for (int unsigned i = 0; i <= GROUP_MAX; i++) begin
      for (int unsigned j = 0; j <= i; j++) begin
        term = src[j];
        for (int unsigned m = j; m < i; m++) begin
          term = term & p[m];
        end
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead cell.
//   p, g : bit propagate / generate of the group (bit 0 = least significant)
//   ci   : carry into bit 0 of the group
//   pg   : group propagate (all bits propagate)
//   gg   : group generate (carry out of the group with ci = 0)
//   c    : carry into each bit of the group, c[0] = ci
module cla_group
  import arith_pkg::*;
#(
  parameter int unsigned GROUP = GROUP_DEFAULT
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             ci,
  output logic             pg,
  output logic             gg,
  output logic [GROUP-1:0] c
);

  logic [GROUP_MAX:0] la_ci;
  logic [GROUP_MAX:0] la_gen;

  assign la_ci  = cla_carries(GROUP_MAX'(p), GROUP_MAX'(g), ci);
  assign la_gen = cla_carries(GROUP_MAX'(p), GROUP_MAX'(g), 1'b0);

  assign c  = la_ci[GROUP-1:0];
  assign pg = &p;
  assign gg = la_gen[GROUP];

  // Upper lookahead bits only exist to pad narrow groups.
  logic unused_la;
  assign unused_la = ^{la_ci[GROUP_MAX:GROUP], la_gen};

endmodule

// File: rtl/pipelined_cla_adder.sv
// Three-stage pipelined carry-lookahead adder: {cout, sum} = a + b + cin.
// A new operand pair is accepted every clock; the result appears two edges
// after the sampling edge.
//   clk  : clock, rising edge
//   sum  : registered sum, [WIDTH:1]
//   cout : registered carry out of bit WIDTH
//   a, b : operands, [WIDTH:1]
//   cin  : carry into bit 1
//   rst  : asynchronous active-high reset, clears every pipeline register
// Stage 1 registers the operands, stage 2 registers bit and group
// propagate/generate, stage 3 resolves group and bit carries and registers
// the result.
module pipelined_cla_adder
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned GROUP = GROUP_DEFAULT
) (
  input  logic           clk,
  output logic [WIDTH:1] sum,
  output logic           cout,
  input  logic [WIDTH:1] a,
  input  logic [WIDTH:1] b,
  input  logic           cin,
  input  logic           rst
);

  localparam int unsigned NG = WIDTH / GROUP;

  // ---------------- stage 1: operand registers ----------------
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;

  // ---------------- stage 2: propagate / generate ----------------
  logic [WIDTH-1:0] p1;
  logic [WIDTH-1:0] g1;
  logic [NG-1:0]    pg1;
  logic [NG-1:0]    gg1;

  logic [WIDTH-1:0] s2_p;
  logic [WIDTH-1:0] s2_g;
  logic [NG-1:0]    s2_pg;
  logic [NG-1:0]    s2_gg;
  logic             s2_cin;

  assign p1 = s1_a ^ s1_b;
  assign g1 = s1_a & s1_b;

  for (genvar k = 0; k < NG; k++) begin : g_s2
    logic [GROUP_MAX:0] la;
    assign la     = cla_carries(GROUP_MAX'(p1[k*GROUP +: GROUP]),
                                GROUP_MAX'(g1[k*GROUP +: GROUP]), 1'b0);
    assign pg1[k] = &p1[k*GROUP +: GROUP];
    assign gg1[k] = la[GROUP];

    // Only the group carry out is needed here.
    logic unused_la;
    assign unused_la = ^la;
  end

  // ---------------- stage 3: carries and sum ----------------
  // Group carries as a flat sum of products over {GG, cin}:
  //   cg[k] = OR over j<=k of ( src[j] & PG[j] & ... & PG[k-1] )
  // which is the unrolled form of cg[k+1] = GG[k] | PG[k] & cg[k].
  logic [NG:0]      cg;
  logic [NG:0]      cg_src;
  logic             cg_term;
  logic [WIDTH-1:0] cbit;
  logic [NG-1:0]    pg3;
  logic [NG-1:0]    gg3;

  assign cg_src = {s2_gg, s2_cin};

  always_comb begin
    cg      = '0;
    cg_term = 1'b0;
    for (int unsigned k = 0; k <= NG; k++) begin
      for (int unsigned j = 0; j <= k; j++) begin
        cg_term = cg_src[j];
        for (int unsigned m = j; m < k; m++) begin
          cg_term = cg_term & s2_pg[m];
        end
        cg[k] = cg[k] | cg_term;
      end
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_s3
    cla_group #(.GROUP(GROUP)) u_grp (
      .p  (s2_p[k*GROUP +: GROUP]),
      .g  (s2_g[k*GROUP +: GROUP]),
      .ci (cg[k]),
      .pg (pg3[k]),
      .gg (gg3[k]),
      .c  (cbit[k*GROUP +: GROUP])
    );
  end

  // Group terms are already taken from the stage-2 registers.
  logic unused_grp;
  assign unused_grp = ^{pg3, gg3};

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_cin <= 1'b0;
      s2_p   <= '0;
      s2_g   <= '0;
      s2_pg  <= '0;
      s2_gg  <= '0;
      s2_cin <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      s1_a   <= a;
      s1_b   <= b;
      s1_cin <= cin;
      s2_p   <= p1;
      s2_g   <= g1;
      s2_pg  <= pg1;
      s2_gg  <= gg1;
      s2_cin <= s1_cin;
      sum    <= s2_p ^ cbit;
      cout   <= cg[NG];
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and random checks of pipelined_cla_adder: reset behaviour,
// two-edge latency with result hold, carry chains across group boundaries,
// and back-to-back throughput against a behavioural reference.
module tb_pipelined_cla_adder;

  localparam int unsigned W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [W:1] a;
  logic [W:1] b;
  logic       cin;
  logic [W:1] sum;
  logic       cout;

  int errors = 0;
  int checks = 0;
  logic [W:0] prev;
  logic [W:0] expq[$];
  logic [W:0] rexp;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk  (clk),
    .sum  (sum),
    .cout (cout),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .rst  (rst)
  );

  task automatic check(input string tag, input logic [W:0] exp);
    checks++;
    assert ({cout, sum} === exp) else begin
      errors++;
      $error("FAIL %s: got {cout,sum}=%h expected %h", tag, {cout, sum}, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are applied just after an edge; the next edge (N) samples them.
  // The previous result must hold after N and N+1, the new one after N+2.
  task automatic vec(input string tag, input logic [W:1] va, input logic [W:1] vb,
                     input logic vc, input logic [W:0] exp);
    a   = va;
    b   = vb;
    cin = vc;
    tick();
    check({tag, " hold N"}, prev);
    tick();
    check({tag, " hold N+1"}, prev);
    tick();
    check(tag, exp);
    prev = exp;
  endtask

  initial begin
    rst  = 1'b1;
    a    = '0;
    b    = '0;
    cin  = 1'b0;
    prev = '0;
    tick();
    tick();
    check("reset state", 33'h0_00000000);
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("idle after reset", 33'h0_00000000);

    vec("single operand", 32'hF8E38E38, 32'h00000000, 1'b0, 33'h0_F8E38E38);
    vec("small add",      32'h00000003, 32'h00000002, 1'b0, 33'h0_00000005);
    vec("full chain cin", 32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000);
    vec("all ones cin",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1_FFFFFFFF);
    vec("group edge",     32'h0000000F, 32'h00000001, 1'b0, 33'h0_00000010);
    vec("msb edge",       32'h7FFFFFFF, 32'h00000001, 1'b0, 33'h0_80000000);
    vec("half carry",     32'h0000FFFF, 32'h00000001, 1'b0, 33'h0_00010000);
    vec("msb overflow",   32'h80000000, 32'h80000000, 1'b0, 33'h1_00000000);
    vec("mixed",          32'h12345678, 32'h87654321, 1'b0, 33'h0_99999999);
    vec("alt propagate",  32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 33'h1_00000000);

    // Reset mid-stream with 5+7 in flight: outputs clear without a clock edge.
    a   = 32'd5;
    b   = 32'd7;
    cin = 1'b0;
    tick();
    tick();
    check("pre-reset hold", prev);
    #3;
    rst = 1'b1;
    #1;
    check("async reset", 33'h0_00000000);
    a   = '0;
    b   = '0;
    cin = 1'b0;
    #2;
    rst = 1'b0;
    tick();
    check("post reset 1", 33'h0_00000000);
    tick();
    check("post reset 2", 33'h0_00000000);
    tick();
    check("post reset 3", 33'h0_00000000);

    // Back-to-back random operands, one per cycle.
    for (int i = 0; i < 1000; i++) begin
      a    = $urandom;
      b    = $urandom;
      cin  = 1'($urandom_range(0, 1));
      rexp = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      expq.push_back(rexp);
      tick();
      if (i >= 2) check("random", expq.pop_front());
    end
    tick();
    check("random drain 1", expq.pop_front());
    tick();
    check("random drain 2", expq.pop_front());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
